// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline, state on the falling clock edge.
// Define HAZARD_STAT_EN to add the stat_* stall/flush/mem-wait counters.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt_addr,
  input  logic [4:0] ifid_rs_addr,
  input  logic [4:0] ifid_rt_addr,
  input  logic       id_uses_rt,
  input  logic       id_uses_hilo,
  input  logic       id_redirect,
  input  logic       mdu_start,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       cu_stall_pc,
  output logic       cu_stall_ifid,
  output logic       cu_flush_ifid,
  output logic       cu_stall_idex,
  output logic       cu_flush_idex,
  output logic       cu_stall_exmem,
  output logic       cu_flush_memwb,
  output logic       mdu_busy,
  output logic       mdu_done
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_flush_cnt,
  output logic [31:0] stat_mem_wait
`endif
);
  typedef enum logic {ST_RUN, ST_MDU} state_e;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mem_wait, load_use, mdu_hold, fe_stall;

  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The countdown ignores stalls and any re-issue while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_RUN) begin
      state_d = mdu_start ? ST_MDU : ST_RUN;
      cnt_d   = mdu_start ? CNT_WIDTH'(MDU_CYCLES - 1) : cnt_q;
    end else begin
      state_d = (cnt_q == '0) ? ST_RUN : ST_MDU;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    mem_wait       = reset & mem_req & ~mem_ready;
    load_use       = reset & idex_mem_read & (idex_rt_addr != '0) &
                     ((idex_rt_addr == ifid_rs_addr) | (id_uses_rt & (idex_rt_addr == ifid_rt_addr)));
    mdu_busy       = reset & (state_q == ST_MDU);
    mdu_done       = mdu_busy & (cnt_q == '0);
    mdu_hold       = mdu_busy & id_uses_hilo & ~mdu_done;
    fe_stall       = mem_wait | load_use | mdu_hold;
    cu_stall_pc    = fe_stall;
    cu_stall_ifid  = fe_stall;
    cu_flush_ifid  = reset & ~fe_stall & id_redirect;
    cu_stall_idex  = mem_wait;
    cu_flush_idex  = ~mem_wait & (load_use | mdu_hold);
    cu_stall_exmem = mem_wait;
    cu_flush_memwb = mem_wait;
  end

`ifdef HAZARD_STAT_EN
  always_ff @(negedge clk) begin
    if (!reset) begin
      stat_stall_cycles <= '0;
      stat_flush_cnt    <= '0;
      stat_mem_wait     <= '0;
    end else begin
      stat_stall_cycles <= stat_stall_cycles + 32'(cu_stall_pc);
      stat_flush_cnt    <= stat_flush_cnt + 32'(cu_flush_ifid);
      stat_mem_wait     <= stat_mem_wait + 32'(mem_wait);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven checks of pipe_hazard_ctrl with MDU_CYCLES=4.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b1;
  logic reset, idex_mem_read, id_uses_rt, id_uses_hilo, id_redirect, mdu_start, mem_req, mem_ready;
  logic [4:0] idex_rt_addr, ifid_rs_addr, ifid_rt_addr;
  logic cu_stall_pc, cu_stall_ifid, cu_flush_ifid, cu_stall_idex, cu_flush_idex;
  logic cu_stall_exmem, cu_flush_memwb, mdu_busy, mdu_done;
  int errors = 0;
  int checks = 0;
`ifdef HAZARD_STAT_EN
  logic [31:0] stat_stall_cycles, stat_flush_cnt, stat_mem_wait;
`endif

  pipe_hazard_ctrl #(.MDU_CYCLES(4), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rt_addr(idex_rt_addr),
    .ifid_rs_addr(ifid_rs_addr), .ifid_rt_addr(ifid_rt_addr), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo), .id_redirect(id_redirect), .mdu_start(mdu_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .cu_stall_pc(cu_stall_pc),
    .cu_stall_ifid(cu_stall_ifid), .cu_flush_ifid(cu_flush_ifid), .cu_stall_idex(cu_stall_idex),
    .cu_flush_idex(cu_flush_idex), .cu_stall_exmem(cu_stall_exmem),
    .cu_flush_memwb(cu_flush_memwb), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef HAZARD_STAT_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_flush_cnt(stat_flush_cnt),
    .stat_mem_wait(stat_mem_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, mr;
    logic [4:0] xrt, drs, drt;
    logic       urt, uhl, rd, ms, mq, mrdy;
    logic [8:0] exp;
  } vec_t;

  // exp bit order: stall_pc stall_ifid flush_ifid stall_idex flush_idex stall_exmem flush_memwb busy done
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] MEMW = 9'b110101100;
  localparam logic [8:0] FLSH = 9'b001000000;
  localparam logic [8:0] BUSY = 9'b000000010;
  localparam logic [8:0] DONE = 9'b000000001;

  vec_t tbl[16];

  function automatic vec_t mk(logic rst, logic mr, logic [4:0] xrt, logic [4:0] drs, logic [4:0] drt,
                              logic urt, logic uhl, logic rd, logic ms, logic mq, logic mrdy,
                              logic [8:0] exp);
    mk = '{rst, mr, xrt, drs, drt, urt, uhl, rd, ms, mq, mrdy, exp};
  endfunction

  task automatic cyc(input vec_t v, input string nm);
    logic [8:0] got;
    @(posedge clk);
    reset = v.rst; idex_mem_read = v.mr; idex_rt_addr = v.xrt; ifid_rs_addr = v.drs;
    ifid_rt_addr = v.drt; id_uses_rt = v.urt; id_uses_hilo = v.uhl; id_redirect = v.rd;
    mdu_start = v.ms; mem_req = v.mq; mem_ready = v.mrdy;
    #2;
    got = {cu_stall_pc, cu_stall_ifid, cu_flush_ifid, cu_stall_idex, cu_flush_idex,
           cu_stall_exmem, cu_flush_memwb, mdu_busy, mdu_done};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", nm, got, v.exp);
    end
  endtask

`ifdef HAZARD_STAT_EN
  task automatic stat_chk(input string nm, input logic [31:0] st, input logic [31:0] fl, input logic [31:0] mw);
    checks++;
    if (stat_stall_cycles !== st || stat_flush_cnt !== fl || stat_mem_wait !== mw) begin
      errors++;
      $display("FAIL %s: stats got %0d/%0d/%0d expected %0d/%0d/%0d", nm,
               stat_stall_cycles, stat_flush_cnt, stat_mem_wait, st, fl, mw);
    end
  endtask
`endif

  initial begin
    tbl[0]  = mk(0, 1, 2, 2, 0, 0, 1, 1, 0, 1, 0, NONE);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    tbl[2]  = mk(1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, LU);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    tbl[5]  = mk(1, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0, NONE);
    tbl[6]  = mk(1, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, LU);
    tbl[7]  = mk(1, 0, 3, 3, 3, 1, 0, 0, 0, 0, 0, NONE);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLSH);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    tbl[10] = mk(1, 1, 5, 5, 0, 0, 0, 1, 0, 0, 0, LU);
    tbl[11] = mk(1, 0, 5, 5, 0, 0, 0, 1, 0, 0, 0, FLSH);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);
    tbl[13] = mk(1, 1, 4, 4, 0, 0, 0, 1, 0, 1, 0, MEMW);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, MEMW);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NONE);
    for (int i = 0; i < 16; i++) cyc(tbl[i], $sformatf("vec%0d", i));
    // MDU busy window with a second start issued mid-count
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE), "mdu_issue");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, LU | BUSY), "mdu_b1");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, LU | BUSY), "mdu_b2_restart");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, LU | BUSY), "mdu_b3");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, BUSY | DONE), "mdu_done");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NONE), "mdu_idle");
    // memory wait during MDU countdown, from a fresh reset
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "mw_reset");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE), "mw_issue");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW | BUSY), "mw_w1");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW | BUSY), "mw_w2");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW | BUSY), "mw_w3");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUSY | DONE), "mw_done");
`ifdef HAZARD_STAT_EN
    stat_chk("mw_stats", 32'd3, 32'd0, 32'd3);
`endif
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "mw_idle");
    // reset asserted while the MDU is busy
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE), "rst_issue");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUSY), "rst_busy");
    cyc(mk(0, 1, 6, 6, 0, 0, 1, 1, 0, 1, 0, NONE), "rst_low");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NONE), "rst_release");
`ifdef HAZARD_STAT_EN
    stat_chk("rst_stats", 32'd0, 32'd0, 32'd0);
`endif
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLSH), "rst_after_flush");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Detects load-use hazards, multi-cycle mult/div (MDU) occupancy, data-memory wait states and ID-stage control redirects.
- Drives the stall and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Holds the only sequential pipeline-control state: the MDU busy countdown, plus the optional stall statistics.

Parameters:
- MDU_CYCLES, 32: cycles the MDU is busy after issue; legal range 2..63.
- CNT_WIDTH, 6: width of the MDU countdown register.

Ports:
- clk  in  1  system clock; all state updates on the falling edge, the same edge the pipeline registers use.
- reset  in  1  synchronous, active-low reset; sampled on the falling edge of clk.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rt_addr  in  5  destination register of that load.
- ifid_rs_addr  in  5  rs field of the instruction in ID.
- ifid_rt_addr  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- id_uses_hilo  in  1  instruction in ID reads HI/LO or issues an MDU op.
- id_redirect  in  1  branch taken or jump resolved in ID.
- mdu_start  in  1  MDU operation issuing from EX this cycle.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes this cycle.
- cu_stall_pc  out  1  hold PC.
- cu_stall_ifid  out  1  hold IF/ID.
- cu_flush_ifid  out  1  clear IF/ID.
- cu_stall_idex  out  1  hold ID/EX.
- cu_flush_idex  out  1  insert bubble into ID/EX.
- cu_stall_exmem  out  1  hold EX/MEM.
- cu_flush_memwb  out  1  insert bubble into MEM/WB.
- mdu_busy  out  1  MDU countdown active.
- mdu_done  out  1  one-cycle pulse on the last busy cycle.

Behaviour:
- Reset (reset==0 at a falling edge): FSM goes to ST_RUN and the counter clears to 0.
- While reset is low, every output is forced to 0 combinationally.
- FSM states:
  - ST_RUN: mdu_start==1 -> ST_MDU, counter <= MDU_CYCLES-1.
  - ST_MDU: counter decrements every edge. The counter keeps running even during memory stalls. When the counter is 0, mdu_done=1 for that cycle, then the next edge goes to ST_RUN.
  - mdu_start while in ST_MDU is ignored and does not restart the count.
- mdu_busy = (state==ST_MDU).
- Hazard conditions (combinational):
  - mem_wait = mem_req & ~mem_ready.
  - load_use = idex_mem_read & (idex_rt_addr!=0) & ((idex_rt_addr==ifid_rs_addr) | (id_uses_rt & idex_rt_addr==ifid_rt_addr)).
  - mdu_hold = mdu_busy & id_uses_hilo & ~mdu_done. The stall releases in the mdu_done cycle.
- Priority, highest first:
  1. mem_wait: cu_stall_pc = cu_stall_ifid = cu_stall_idex = cu_stall_exmem = 1, cu_flush_memwb = 1. All other flushes are 0.
  2. load_use or mdu_hold: cu_stall_pc = cu_stall_ifid = 1, cu_flush_idex = 1. EX/MEM advances.
  3. id_redirect: cu_flush_ifid = 1 for exactly that cycle. No stalls.
- Stalls and flushes are never asserted together on the same register; the higher priority wins.
- A redirect suppressed by a stall is not lost. The branch stays held in ID, re-asserts id_redirect, and is serviced in the first unstalled cycle.
- Response is zero-latency: outputs are combinational from inputs and state in the same cycle.

Optional Feature:
- Macro: HAZARD_STAT_EN.
- When defined, adds three 32-bit outputs:
  - stat_stall_cycles: cycles with cu_stall_pc==1.
  - stat_flush_cnt: cycles with cu_flush_ifid==1.
  - stat_mem_wait: cycles with mem_wait==1.
- The counters wrap at 2^32 and are cleared by reset.
- When undefined, neither the ports nor the registers exist, and the remaining behaviour is identical.

Test Plan:
- Load-use on rs: idex_mem_read=1, idex_rt_addr=2, ifid_rs_addr=2 for one cycle -> cu_stall_pc, cu_stall_ifid and cu_flush_idex are 1 for exactly that cycle; with idex_rt_addr=0 -> all outputs 0.
- Load-use on rt: rt match with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> one-cycle stall.
- MDU (MDU_CYCLES=4): mdu_start pulse, then id_uses_hilo=1 held.
  - mdu_busy is 1 for 4 cycles.
  - The front-end stall lasts 3 cycles.
  - mdu_done pulses in the 4th busy cycle.
  - A second mdu_start during busy does not extend the count.
- Redirect: id_redirect alone -> cu_flush_ifid=1 for one cycle.
  - Redirect together with load_use -> stall only, no flush.
  - On the next cycle (load_use=0) -> flush.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles during ST_MDU -> all four stalls plus cu_flush_memwb for 3 cycles; the MDU counter still decrements by 3. With HAZARD_STAT_EN, stat_mem_wait=3.
- Reset mid-operation: reset=0 at one falling edge during ST_MDU -> all outputs 0 while reset is low; after release mdu_busy=0 and stat counters read 0.
